rtc_timer_bank: RTL and testbench
=================================

# rtc_timer_bank

Multi-channel timer/RTC peripheral on the 24-bit I/O command bus: {opcode[23:16], data[15:0]} in, one-cycle `rdy` strobe with {opcode, data} out. It generalises the single-counter RTC to CHANNELS independent counters with a shared programmable prescaler, per-channel compare/alarm with mode control, an interrupt output and a parametrised active-low LED bank. Single clock domain; the prescaler replaces a separate divided clock.

## Interface
- CHANNELS, 4, number of counter channels (1..16)
- CW, 16, counter and compare width (1..16)
- PSW, 16, prescaler divider width (1..16)
- NLED, 4, number of LED outputs (1..16)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command valid; one command accepted per cycle
- in  in  24  command: [23:16] opcode, [15:0] data
- rdy  out  1  one-cycle reply strobe
- out  out  24  reply {opcode, data}; valid when rdy=1
- irq  out  1  OR of all channel alarm flags
- led  out  NLED  LED drive, active-low (led = ~led_reg)

## Operation
- Per channel: run bit, count[CW], cmp[CW], mode[2], flag. Global: sel (channel select), presc_div[PSW], presc_cnt[PSW], led_reg[NLED].
- Reset values: count 0, cmp all-ones, mode 0, run 0, flag 0, sel 0, presc_div 0, presc_cnt 0, led_reg 0 (led all 1), rdy 0, out 0, irq 0.
- Opcodes (in[23:16]); all channel ops act on channel `sel`; unknown opcodes ignored, no reply:
  - 1 RUN: run=1. 2 STOP: run=0, count held.
  - 3 SET: count = in[CW-1:0].
  - 4 GET: reply {8'd4, zero-extended count}.
  - 5 ON / 6 OFF: led_reg[in[3:0]] = 1 / 0; index >= NLED ignored.
  - 7 SEL: sel = in[3:0]; value >= CHANNELS ignored (sel unchanged).
  - 8 PRESC: presc_div = in[PSW-1:0]; presc_cnt cleared to 0.
  - 9 ALARM: cmp = in[CW-1:0].
  - 10 MODE: mode = in[1:0]. 11 CLRIRQ: flag = 0.
  - 12 STAT: reply {8'd12, flags zero-extended to 16}, bit i = channel i.
- Prescaler: free-running, independent of run bits. tick=1 when presc_cnt == presc_div, then presc_cnt wraps to 0; otherwise increments. Tick period = presc_div+1 cycles; presc_div=0 → tick every cycle.
- On tick, each channel with run=1:
  - count != cmp: count = count+1 modulo 2^CW.
  - count == cmp: flag=1, then by mode: 0 free-run (count+1, wraps); 1 auto-reload (count=0); 2 one-shot (count held at cmp, run=0); 3 behaves as 0.
- irq = |flag, driven from registers (no combinational path from `in`).
- Precedence, same cycle:
  - SET vs tick on selected channel: SET wins, no increment.
  - CLRIRQ vs new match: set wins, flag stays 1.
  - STOP vs tick: STOP wins, no increment, no match.
  - RUN vs tick: channel not counted on that tick.
  - GET/STAT vs tick: reply shows pre-tick state.
  - PRESC vs tick: presc_cnt = 0, tick on that cycle still processed.
- Unselected channels continue counting during any command.

## Timing
- Command sampled on the clk edge where start=1; register updates visible the next cycle.
- GET/STAT: rdy=1 and out valid exactly 1 cycle after the start cycle, for 1 cycle; out returns to 0 when rdy=0.
- Back-to-back GETs on consecutive cycles yield rdy on consecutive cycles; no stall, no backpressure.
- Counter update, flag set and irq rise occur at the edge of the tick cycle; irq visible next cycle.
- rst asserted mid-operation: all state returns to reset values at that edge; a command on that cycle is dropped, a pending reply is not emitted.

## Test plan
- Reset, then GET → rdy one cycle later, out=24'h040000; led=4'hF; irq=0.
- PRESC 3, SET 0, RUN; after 40 cycles STOP, GET → count 10 (±1 per alignment); second GET after 20 more cycles returns identical value.
- ALARM 5, MODE 1, PRESC 0, RUN → irq rises 6 cycles after RUN, count sequence 0..5,0,1...; CLRIRQ drops irq; rematch re-asserts it; CLRIRQ on match cycle leaves irq=1.
- MODE 2, ALARM 3 on channel 2 (SEL 2), channel 0 free-running → channel 2 stops at 3, STAT returns 24'h0C0004, channel 0 keeps counting; SEL 9 ignored (GET still reads channel 2).
- CW=4 build, free-run from SET 14 → count 14,15,0 wrap; SET on a tick cycle loads exact value with no increment.
- ON 0, ON 3, OFF 0 → led=4'b0111; ON 7 with NLED=4 → no change; rst mid-count → all outputs to reset values next cycle.

Source files
------------

// File: rtl/rtc_timer_bank.sv
// Multi-channel timer/RTC peripheral on the 24-bit I/O command bus.
// A shared programmable prescaler produces a tick. Each channel has a
// counter, a compare/alarm register, a match mode and an alarm flag.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst    synchronous active-high reset
//   start  command valid, one command accepted per cycle
//   in     command {opcode[23:16], data[15:0]}
//   rdy    one-cycle reply strobe (GET/STAT)
//   out    reply {opcode, data}, zero when rdy is low
//   irq    OR of all channel alarm flags
//   led    active-low LED drive
module rtc_timer_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned PSW      = 16,
  parameter int unsigned NLED     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [23:0]     in,
  output logic            rdy,
  output logic [23:0]     out,
  output logic            irq,
  output logic [NLED-1:0] led
);

  localparam logic [7:0] OP_RUN    = 8'd1;
  localparam logic [7:0] OP_STOP   = 8'd2;
  localparam logic [7:0] OP_SET    = 8'd3;
  localparam logic [7:0] OP_GET    = 8'd4;
  localparam logic [7:0] OP_ON     = 8'd5;
  localparam logic [7:0] OP_OFF    = 8'd6;
  localparam logic [7:0] OP_SEL    = 8'd7;
  localparam logic [7:0] OP_PRESC  = 8'd8;
  localparam logic [7:0] OP_ALARM  = 8'd9;
  localparam logic [7:0] OP_MODE   = 8'd10;
  localparam logic [7:0] OP_CLRIRQ = 8'd11;
  localparam logic [7:0] OP_STAT   = 8'd12;

  logic [CW-1:0]       count_q [CHANNELS];
  logic [CW-1:0]       count_d [CHANNELS];
  logic [CW-1:0]       cmp_q   [CHANNELS];
  logic [CW-1:0]       cmp_d   [CHANNELS];
  logic [1:0]          mode_q  [CHANNELS];
  logic [1:0]          mode_d  [CHANNELS];
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic [3:0]          sel_q, sel_d;
  logic [PSW-1:0]      presc_div_q, presc_div_d;
  logic [PSW-1:0]      presc_cnt_q, presc_cnt_d;
  logic [NLED-1:0]     led_q, led_d;
  logic                rdy_q, rdy_d;
  logic [23:0]         out_q, out_d;
  logic                irq_q, irq_d;

  logic [7:0]          op;
  logic                tick;
  logic                match;
  logic [CW-1:0]       sel_count;

  // Command decode, prescaler and per-channel counter next state.
  always_comb begin
    count_d     = count_q;
    cmp_d       = cmp_q;
    mode_d      = mode_q;
    run_d       = run_q;
    flag_d      = flag_q;
    sel_d       = sel_q;
    presc_div_d = presc_div_q;
    led_d       = led_q;
    rdy_d       = 1'b0;
    out_d       = 24'd0;
    match       = 1'b0;
    sel_count   = '0;

    op          = start ? in[23:16] : 8'd0;
    tick        = (presc_cnt_q == presc_div_q);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PSW'(1);

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (4'(i) == sel_q) sel_count = count_q[i];
    end

    // Global commands; replies always carry pre-tick state.
    case (op)
      OP_GET: begin
        rdy_d = 1'b1;
        out_d = {OP_GET, 16'(sel_count)};
      end
      OP_STAT: begin
        rdy_d = 1'b1;
        out_d = {OP_STAT, 16'(flag_q)};
      end
      OP_ON, OP_OFF: begin
        for (int unsigned j = 0; j < NLED; j++) begin
          if (4'(j) == in[3:0]) led_d[j] = (op == OP_ON);
        end
      end
      OP_SEL: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (4'(i) == in[3:0]) sel_d = in[3:0];
        end
      end
      OP_PRESC: begin
        presc_div_d = in[PSW-1:0];
        presc_cnt_d = '0;
      end
      default: ;
    endcase

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // Tick processing first; selected-channel commands then override it.
      match = run_q[i] && tick && (count_q[i] == cmp_q[i]);
      if (run_q[i] && tick) begin
        if (match) begin
          flag_d[i] = 1'b1;
          case (mode_q[i])
            2'd1:    count_d[i] = '0;
            2'd2:    run_d[i]   = 1'b0;
            default: count_d[i] = count_q[i] + CW'(1);
          endcase
        end else begin
          count_d[i] = count_q[i] + CW'(1);
        end
      end

      if (4'(i) == sel_q) begin
        case (op)
          OP_RUN: begin
            run_d[i]   = 1'b1;
            count_d[i] = count_q[i];
            flag_d[i]  = flag_q[i];
          end
          OP_STOP: begin
            run_d[i]   = 1'b0;
            count_d[i] = count_q[i];
            flag_d[i]  = flag_q[i];
          end
          OP_SET:    count_d[i] = in[CW-1:0];
          OP_ALARM:  cmp_d[i]   = in[CW-1:0];
          OP_MODE:   mode_d[i]  = in[1:0];
          OP_CLRIRQ: flag_d[i]  = match;
          default: ;
        endcase
      end
    end

    irq_d = |flag_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count_q[i] <= '0;
        cmp_q[i]   <= '1;
        mode_q[i]  <= 2'd0;
      end
      run_q       <= '0;
      flag_q      <= '0;
      sel_q       <= 4'd0;
      presc_div_q <= '0;
      presc_cnt_q <= '0;
      led_q       <= '0;
      rdy_q       <= 1'b0;
      out_q       <= 24'd0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      flag_q      <= flag_d;
      sel_q       <= sel_d;
      presc_div_q <= presc_div_d;
      presc_cnt_q <= presc_cnt_d;
      led_q       <= led_d;
      rdy_q       <= rdy_d;
      out_q       <= out_d;
      irq_q       <= irq_d;
    end
  end

  assign rdy = rdy_q;
  assign out = out_q;
  assign irq = irq_q;
  assign led = ~led_q;

endmodule

// File: tb/tb_rtc_timer_bank.sv
// Self-checking bench for rtc_timer_bank: a vector table for the
// single-command behaviour plus hand-written multi-cycle sequences.
module tb_rtc_timer_bank;

  localparam logic [7:0] OP_RUN    = 8'd1;
  localparam logic [7:0] OP_STOP   = 8'd2;
  localparam logic [7:0] OP_SET    = 8'd3;
  localparam logic [7:0] OP_GET    = 8'd4;
  localparam logic [7:0] OP_ON     = 8'd5;
  localparam logic [7:0] OP_OFF    = 8'd6;
  localparam logic [7:0] OP_SEL    = 8'd7;
  localparam logic [7:0] OP_PRESC  = 8'd8;
  localparam logic [7:0] OP_ALARM  = 8'd9;
  localparam logic [7:0] OP_MODE   = 8'd10;
  localparam logic [7:0] OP_CLRIRQ = 8'd11;
  localparam logic [7:0] OP_STAT   = 8'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic [23:0] in, in4;
  logic        rdy, rdy4;
  logic [23:0] out, out4;
  logic        irq, irq4;
  logic [3:0]  led, led4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtc_timer_bank u_dut (
    .clk(clk), .rst(rst), .start(start), .in(in),
    .rdy(rdy), .out(out), .irq(irq), .led(led)
  );

  rtc_timer_bank #(.CW(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in(in4),
    .rdy(rdy4), .out(out4), .irq(irq4), .led(led4)
  );

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    logic        exp_rdy;
    logic [23:0] exp_out;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command (tgt 0 = default build, 1 = CW=4 build); starts and ends at a negedge.
  task automatic do_cmd(input int tgt, input logic [7:0] op, input logic [15:0] d);
    if (tgt == 0) begin start = 1'b1; in = {op, d}; end
    else begin start4 = 1'b1; in4 = {op, d}; end
    @(negedge clk);
    start = 1'b0; in = 24'd0;
    start4 = 1'b0; in4 = 24'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{OP_ON,    16'd0,      1'b0, 24'h000000, 4'hE};
    vecs[1]  = '{OP_ON,    16'd3,      1'b0, 24'h000000, 4'h6};
    vecs[2]  = '{OP_OFF,   16'd0,      1'b0, 24'h000000, 4'h7};
    vecs[3]  = '{OP_ON,    16'd7,      1'b0, 24'h000000, 4'h7};
    vecs[4]  = '{8'h55,    16'hFFFF,   1'b0, 24'h000000, 4'h7};
    vecs[5]  = '{OP_SET,   16'h1234,   1'b0, 24'h000000, 4'h7};
    vecs[6]  = '{OP_GET,   16'd0,      1'b1, 24'h041234, 4'h7};
    vecs[7]  = '{OP_SEL,   16'd9,      1'b0, 24'h000000, 4'h7};
    vecs[8]  = '{OP_GET,   16'd0,      1'b1, 24'h041234, 4'h7};
    vecs[9]  = '{OP_SEL,   16'd1,      1'b0, 24'h000000, 4'h7};
    vecs[10] = '{OP_GET,   16'd0,      1'b1, 24'h040000, 4'h7};
    vecs[11] = '{OP_SET,   16'h0007,   1'b0, 24'h000000, 4'h7};
    vecs[12] = '{OP_SEL,   16'd0,      1'b0, 24'h000000, 4'h7};
    vecs[13] = '{OP_STAT,  16'd0,      1'b1, 24'h0C0000, 4'h7};
    vecs[14] = '{OP_SEL,   16'd1,      1'b0, 24'h000000, 4'h7};
    vecs[15] = '{OP_GET,   16'd0,      1'b1, 24'h040007, 4'h7};
    vecs[16] = '{OP_OFF,   16'd3,      1'b0, 24'h000000, 4'hF};

    rst = 1'b1; start = 1'b0; in = 24'd0; start4 = 1'b0; in4 = 24'd0;
    @(negedge clk);
    reset_dut();

    // Reset state and first GET.
    check("reset_rdy", 24'(rdy), 24'd0);
    check("reset_out", out, 24'd0);
    check("reset_irq", 24'(irq), 24'd0);
    check("reset_led", 24'(led), 24'hF);
    do_cmd(0, OP_GET, 16'd0);
    check("reset_get_rdy", 24'(rdy), 24'd1);
    check("reset_get_out", out, 24'h040000);
    idle(1);
    check("reply_drop_rdy", 24'(rdy), 24'd0);
    check("reply_drop_out", out, 24'd0);

    // Table-driven single commands (channels stopped).
    for (int v = 0; v < 17; v++) begin
      do_cmd(0, vecs[v].op, vecs[v].data);
      check($sformatf("vec%0d_rdy", v), 24'(rdy), 24'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
      check($sformatf("vec%0d_led", v), 24'(led), 24'(vecs[v].exp_led));
    end

    // Prescaler 3: ticks every 4 cycles; STOP holds count.
    reset_dut();
    do_cmd(0, OP_PRESC, 16'd3);
    do_cmd(0, OP_SET, 16'd0);
    do_cmd(0, OP_RUN, 16'd0);
    idle(40);
    do_cmd(0, OP_STOP, 16'd0);
    do_cmd(0, OP_GET, 16'd0);
    check("presc_get1", out, 24'h04000A);
    idle(20);
    do_cmd(0, OP_GET, 16'd0);
    check("presc_get2", out, 24'h04000A);
    check("presc_irq", 24'(irq), 24'd0);

    // Auto-reload alarm, CLRIRQ, rematch, CLRIRQ on match cycle.
    reset_dut();
    do_cmd(0, OP_ALARM, 16'd5);
    do_cmd(0, OP_MODE, 16'd1);
    do_cmd(0, OP_PRESC, 16'd0);
    do_cmd(0, OP_RUN, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check($sformatf("alarm_irq_c%0d", k), 24'(irq), (k == 6) ? 24'd1 : 24'd0);
    end
    do_cmd(0, OP_GET, 16'd0);
    check("reload_get0_rdy", 24'(rdy), 24'd1);
    check("reload_get0", out, 24'h040000);
    do_cmd(0, OP_GET, 16'd0);
    check("reload_get1_rdy", 24'(rdy), 24'd1);
    check("reload_get1", out, 24'h040001);
    do_cmd(0, OP_CLRIRQ, 16'd0);
    check("clrirq_drop", 24'(irq), 24'd0);
    idle(2);
    check("clrirq_low", 24'(irq), 24'd0);
    idle(1);
    check("rematch_irq", 24'(irq), 24'd1);
    do_cmd(0, OP_CLRIRQ, 16'd0);
    check("clrirq_drop2", 24'(irq), 24'd0);
    idle(4);
    check("pre_match_irq", 24'(irq), 24'd0);
    do_cmd(0, OP_CLRIRQ, 16'd0);
    check("clrirq_on_match", 24'(irq), 24'd1);

    // One-shot on channel 2, channel 0 free-running.
    reset_dut();
    do_cmd(0, OP_SEL, 16'd2);
    do_cmd(0, OP_MODE, 16'd2);
    do_cmd(0, OP_ALARM, 16'd3);
    do_cmd(0, OP_RUN, 16'd0);
    do_cmd(0, OP_SEL, 16'd0);
    do_cmd(0, OP_RUN, 16'd0);
    idle(3);
    do_cmd(0, OP_STAT, 16'd0);
    check("oneshot_stat", out, 24'h0C0004);
    do_cmd(0, OP_SEL, 16'd2);
    do_cmd(0, OP_SEL, 16'd9);
    do_cmd(0, OP_GET, 16'd0);
    check("oneshot_held", out, 24'h040003);
    do_cmd(0, OP_SEL, 16'd0);
    do_cmd(0, OP_GET, 16'd0);
    check("ch0_count_a", out, 24'h040008);
    do_cmd(0, OP_GET, 16'd0);
    check("ch0_count_b", out, 24'h040009);
    check("oneshot_irq", 24'(irq), 24'd1);

    // Reset mid-count with a GET on the reset cycle.
    do_cmd(0, OP_ON, 16'd1);
    check("led_on1", 24'(led), 24'hD);
    rst = 1'b1; start = 1'b1; in = {OP_GET, 16'd0};
    @(negedge clk);
    start = 1'b0; in = 24'd0; rst = 1'b0;
    check("rst_mid_rdy", 24'(rdy), 24'd0);
    check("rst_mid_out", out, 24'd0);
    check("rst_mid_irq", 24'(irq), 24'd0);
    check("rst_mid_led", 24'(led), 24'hF);
    do_cmd(0, OP_GET, 16'd0);
    check("rst_mid_get", out, 24'h040000);

    // CW=4 build: wrap 14,15,0 and SET on a tick cycle.
    do_cmd(1, OP_SET, 16'd14);
    do_cmd(1, OP_RUN, 16'd0);
    check("cw4_irq_pre", 24'(irq4), 24'd0);
    do_cmd(1, OP_GET, 16'd0);
    check("cw4_get14", out4, 24'h04000E);
    do_cmd(1, OP_GET, 16'd0);
    check("cw4_get15_rdy", 24'(rdy4), 24'd1);
    check("cw4_get15", out4, 24'h04000F);
    do_cmd(1, OP_GET, 16'd0);
    check("cw4_get0", out4, 24'h040000);
    check("cw4_irq_wrap", 24'(irq4), 24'd1);
    do_cmd(1, OP_SET, 16'd9);
    do_cmd(1, OP_GET, 16'd0);
    check("cw4_set_on_tick", out4, 24'h040009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
